result_writeback: RTL and testbench

RESULT_WRITEBACK -- requirements
Module: result_writeback

---
 rtl/result_writeback_if.sv | 41 ++++
 rtl/result_writeback.sv | 106 ++++++++++
 tb/tb_result_writeback.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/result_writeback_if.sv
// Result writeback bus: retirement stream in, per-unit result ports,
// register-file write port and operand-forwarding port.
// Ports (by modport):
//   master : drives in_shift/in_valid/in_dest/in_src, unit_valid/unit_data,
//            fwd_addr; observes stall, unit_ack, rf_we/rf_addr/rf_data,
//            busy, overflow, fwd_hit/fwd_data.
//   slave  : the writeback block itself (mirror directions).
interface result_writeback_if #(
  parameter int unsigned DEST_SIZE  = 5,
  parameter int unsigned SRC_SIZE   = 3,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned NUM_UNITS = 2 ** SRC_SIZE;

  logic                                  in_shift;
  logic                                  in_valid;
  logic [DEST_SIZE-1:0]                  in_dest;
  logic [SRC_SIZE-1:0]                   in_src;
  logic                                  stall;
  logic [NUM_UNITS-1:0]                  unit_valid;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  unit_data;
  logic [NUM_UNITS-1:0]                  unit_ack;
  logic                                  rf_we;
  logic [DEST_SIZE-1:0]                  rf_addr;
  logic [DATA_WIDTH-1:0]                 rf_data;
  logic                                  busy;
  logic                                  overflow;
  logic [DEST_SIZE-1:0]                  fwd_addr;
  logic                                  fwd_hit;
  logic [DATA_WIDTH-1:0]                 fwd_data;

  modport master (
    output in_shift, in_valid, in_dest, in_src, unit_valid, unit_data, fwd_addr,
    input  stall, unit_ack, rf_we, rf_addr, rf_data, busy, overflow, fwd_hit, fwd_data
  );

  modport slave (
    input  in_shift, in_valid, in_dest, in_src, unit_valid, unit_data, fwd_addr,
    output stall, unit_ack, rf_we, rf_addr, rf_data, busy, overflow, fwd_hit, fwd_data
  );
endinterface

// File: rtl/result_writeback.sv
// In-order result writeback: retiring {dest, src} pairs are queued in a
// small FIFO; the head waits for its functional unit's result, acknowledges
// it and writes it to the register file one cycle later.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : result_writeback_if.slave (retire stream, unit results,
//              register-file write, status, forwarding)
// Optional feature: define RESULT_WRITEBACK_FWD_EN to enable the
// register-file-write forwarding comparator; otherwise fwd_hit/fwd_data are 0.
module result_writeback #(
  parameter int unsigned DEST_SIZE  = 5,
  parameter int unsigned SRC_SIZE   = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input logic               clk,
  input logic               reset_n,
  result_writeback_if.slave bus
);
  localparam int unsigned NUM_UNITS = 2 ** SRC_SIZE;
  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  typedef struct packed {
    logic [DEST_SIZE-1:0] dest;
    logic [SRC_SIZE-1:0]  src;
  } entry_t;

  entry_t                r_mem [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic                  r_rf_we;
  logic                  r_overflow;
  logic [DEST_SIZE-1:0]  r_rf_addr;
  logic [DATA_WIDTH-1:0] r_rf_data;

  entry_t                w_head;
  entry_t                w_new;
  logic                  w_full;
  logic                  w_retire;
  logic                  w_push;
  logic                  w_pop;

  // Stall depends only on the registered count, never on this cycle's inputs.
  assign w_head   = r_mem[r_head];
  assign w_new    = '{dest: bus.in_dest, src: bus.in_src};
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_retire = bus.in_shift & bus.in_valid;
  assign w_push   = w_retire & ~w_full;
  assign w_pop    = (r_count != '0) & bus.unit_valid[w_head.src];

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_rf_we    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_rf_we    <= w_pop;
      r_overflow <= r_overflow | (w_retire & w_full);
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage, not reset: contents are only ever read behind a valid count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_new;
  end

  // Register-file write payload, captured on the dequeue cycle.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_rf_addr <= w_head.dest;
      r_rf_data <= bus.unit_data[w_head.src];
    end
  end

  assign bus.stall    = w_full;
  assign bus.unit_ack = w_pop ? (NUM_UNITS'(1) << w_head.src) : '0;
  assign bus.rf_we    = r_rf_we;
  assign bus.rf_addr  = r_rf_addr;
  assign bus.rf_data  = r_rf_data;
  assign bus.busy     = (r_count != '0) | r_rf_we;
  assign bus.overflow = r_overflow;

`ifdef RESULT_WRITEBACK_FWD_EN
  // Forward the value being written this cycle to a matching operand read.
  assign bus.fwd_hit  = r_rf_we & (bus.fwd_addr == r_rf_addr);
  assign bus.fwd_data = r_rf_data;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^bus.fwd_addr;
  assign bus.fwd_hit  = 1'b0;
  assign bus.fwd_data = '0;
`endif
endmodule

// File: tb/tb_result_writeback.sv
module tb_result_writeback;
  localparam int unsigned DEPTH = 4;

`ifdef RESULT_WRITEBACK_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  result_writeback_if #(.DEST_SIZE(5), .SRC_SIZE(3), .DATA_WIDTH(32)) bus ();

  result_writeback #(.DEST_SIZE(5), .SRC_SIZE(3), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          sh;
    bit          vl;
    logic [4:0]  dest;
    logic [2:0]  src;
    logic [7:0]  uv;
    logic [31:0] data;
    logic [4:0]  fa;
    bit          e_stall;
    logic [7:0]  e_ack;
    bit          e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    bit          e_busy;
    bit          e_ovf;
    bit          e_hit;
  } vec_t;

  typedef struct {
    logic [4:0] dest;
    logic [2:0] src;
  } ent_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Unit u presents data + u, so every unit carries a distinct value.
  task automatic drive(input bit rst, input bit sh, input bit vl, input logic [4:0] dest,
                       input logic [2:0] src, input logic [7:0] uv, input logic [31:0] data,
                       input logic [4:0] fa);
    reset_n        = ~rst;
    bus.in_shift   = sh;
    bus.in_valid   = vl;
    bus.in_dest    = dest;
    bus.in_src     = src;
    bus.unit_valid = uv;
    for (int u = 0; u < 8; u++) bus.unit_data[u] = data + 32'(u);
    bus.fwd_addr   = fa;
  endtask

  function automatic void add(input int rst, input int sh, input int vl, input int dest,
                              input int src, input int uv, input int data, input int fa,
                              input int st, input int ack, input int we, input int addr,
                              input int wd, input int bsy, input int ovf, input int hit);
    vec_t v;
    v.rst = 1'(rst);   v.sh = 1'(sh);       v.vl = 1'(vl);
    v.dest = 5'(dest); v.src = 3'(src);     v.uv = 8'(uv);
    v.data = 32'(data); v.fa = 5'(fa);
    v.e_stall = 1'(st); v.e_ack = 8'(ack);  v.e_we = 1'(we);
    v.e_addr = 5'(addr); v.e_data = 32'(wd); v.e_busy = 1'(bsy);
    v.e_ovf = 1'(ovf);  v.e_hit = 1'(hit);
    tv.push_back(v);
  endfunction

  initial begin
    ent_t        q[$];
    bit          m_we;
    bit          m_ovf;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          rst_now, sh, vl, pop, full;
    logic [4:0]  dest, fa;
    logic [2:0]  src;
    logic [7:0]  uv, e_ack;
    logic [31:0] data;

    //   rst sh vl dest src uv   data          fa | stall ack  we addr wdata        busy ovf hit
    // single writeback with one-cycle latency
    add(0, 0, 0, 0,  0, 8'h00, 0,            0,   0, 8'h00, 0, 0,  0,            0, 0, 0);
    add(0, 1, 1, 3,  2, 8'h00, 0,            0,   0, 8'h00, 0, 0,  0,            0, 0, 0);
    add(0, 0, 0, 0,  0, 8'h04, 32'hA5A5A5A3, 0,   0, 8'h04, 0, 0,  0,            1, 0, 0);
    add(0, 0, 0, 0,  0, 8'h00, 0,            0,   0, 8'h00, 1, 3,  32'hA5A5A5A5, 1, 0, 0);
    add(0, 0, 0, 0,  0, 8'h00, 0,            0,   0, 8'h00, 0, 0,  0,            0, 0, 0);
    // fill, overflow on fifth entry, release by head unit
    add(0, 1, 1, 1,  1, 8'h00, 0,            0,   0, 8'h00, 0, 0,  0,            0, 0, 0);
    add(0, 1, 1, 2,  3, 8'h00, 0,            0,   0, 8'h00, 0, 0,  0,            1, 0, 0);
    add(0, 1, 1, 4,  5, 8'h00, 0,            0,   0, 8'h00, 0, 0,  0,            1, 0, 0);
    add(0, 1, 1, 5,  7, 8'h00, 0,            0,   0, 8'h00, 0, 0,  0,            1, 0, 0);
    add(0, 1, 1, 6,  0, 8'h00, 0,            0,   1, 8'h00, 0, 0,  0,            1, 0, 0);
    add(0, 0, 0, 0,  0, 8'h00, 0,            0,   1, 8'h00, 0, 0,  0,            1, 1, 0);
    add(0, 0, 0, 0,  0, 8'h02, 32'h100,      0,   1, 8'h02, 0, 0,  0,            1, 1, 0);
    add(0, 0, 0, 0,  0, 8'h00, 0,            0,   0, 8'h00, 1, 1,  32'h101,      1, 1, 0);
    // reset with three pending entries, nothing written after release
    add(1, 0, 0, 0,  0, 8'hFF, 0,            0,   0, 8'h00, 0, 0,  0,            0, 0, 0);
    add(0, 0, 0, 0,  0, 8'hFF, 0,            0,   0, 8'h00, 0, 0,  0,            0, 0, 0);
    add(0, 0, 0, 0,  0, 8'hFF, 0,            0,   0, 8'h00, 0, 0,  0,            0, 0, 0);
    // head blocks other valid units; order preserved
    add(0, 1, 1, 9,  1, 8'h01, 0,            0,   0, 8'h00, 0, 0,  0,            0, 0, 0);
    add(0, 1, 1, 10, 0, 8'h01, 0,            0,   0, 8'h00, 0, 0,  0,            1, 0, 0);
    add(0, 0, 0, 0,  0, 8'h01, 0,            0,   0, 8'h00, 0, 0,  0,            1, 0, 0);
    add(0, 0, 0, 0,  0, 8'h03, 32'h200,      0,   0, 8'h02, 0, 0,  0,            1, 0, 0);
    add(0, 0, 0, 0,  0, 8'h03, 32'h300,      0,   0, 8'h01, 1, 9,  32'h201,      1, 0, 0);
    add(0, 0, 0, 0,  0, 8'h00, 0,            0,   0, 8'h00, 1, 10, 32'h300,      1, 0, 0);
    add(0, 0, 0, 0,  0, 8'h00, 0,            0,   0, 8'h00, 0, 0,  0,            0, 0, 0);
    // shift without valid enqueues nothing
    add(0, 1, 0, 8,  0, 8'h00, 0,            0,   0, 8'h00, 0, 0,  0,            0, 0, 0);
    add(0, 0, 0, 0,  0, 8'hFF, 0,            0,   0, 8'h00, 0, 0,  0,            0, 0, 0);
    // forwarding around two writes to r7
    add(0, 1, 1, 7,  0, 8'h00, 0,            0,   0, 8'h00, 0, 0,  0,            0, 0, 0);
    add(0, 1, 1, 7,  0, 8'h00, 0,            0,   0, 8'h00, 0, 0,  0,            1, 0, 0);
    add(0, 0, 0, 0,  0, 8'h01, 32'h600,      0,   0, 8'h01, 0, 0,  0,            1, 0, 0);
    add(0, 0, 0, 0,  0, 8'h01, 32'h700,      7,   0, 8'h01, 1, 7,  32'h600,      1, 0, 1);
    add(0, 0, 0, 0,  0, 8'h00, 0,            6,   0, 8'h00, 1, 7,  32'h700,      1, 0, 0);
    add(0, 0, 0, 0,  0, 8'h00, 0,            7,   0, 8'h00, 0, 0,  0,            0, 0, 0);
    // full FIFO: freed slot still stalls; push+pop at count 3 keeps count
    add(0, 1, 1, 11, 3, 8'h00, 0,            0,   0, 8'h00, 0, 0,  0,            0, 0, 0);
    add(0, 1, 1, 12, 3, 8'h00, 0,            0,   0, 8'h00, 0, 0,  0,            1, 0, 0);
    add(0, 1, 1, 13, 3, 8'h00, 0,            0,   0, 8'h00, 0, 0,  0,            1, 0, 0);
    add(0, 1, 1, 14, 3, 8'h00, 0,            0,   0, 8'h00, 0, 0,  0,            1, 0, 0);
    add(0, 1, 1, 15, 3, 8'h08, 32'h400,      0,   1, 8'h08, 0, 0,  0,            1, 0, 0);
    add(0, 1, 1, 16, 3, 8'h08, 32'h500,      0,   0, 8'h08, 1, 11, 32'h403,      1, 1, 0);
    add(0, 0, 0, 0,  0, 8'h00, 0,            0,   0, 8'h00, 1, 12, 32'h503,      1, 1, 0);
    add(0, 1, 1, 17, 3, 8'h00, 0,            0,   0, 8'h00, 0, 0,  0,            1, 1, 0);
    add(0, 0, 0, 0,  0, 8'h00, 0,            0,   1, 8'h00, 0, 0,  0,            1, 1, 0);

    // power-on reset
    drive(1, 0, 0, 0, 0, 8'h00, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset stall", 32'(bus.stall), 0);
    chk("reset busy",  32'(bus.busy), 0);
    chk("reset rf_we", 32'(bus.rf_we), 0);
    chk("reset ovf",   32'(bus.overflow), 0);
    chk("reset ack",   32'(bus.unit_ack), 0);
    chk("reset hit",   32'(bus.fwd_hit), 0);

    // directed vectors: drive at negedge, check mid-cycle
    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].rst, tv[i].sh, tv[i].vl, tv[i].dest, tv[i].src, tv[i].uv, tv[i].data, tv[i].fa);
      #1;
      chk($sformatf("v%0d stall", i), 32'(bus.stall), 32'(tv[i].e_stall));
      chk($sformatf("v%0d ack", i),   32'(bus.unit_ack), 32'(tv[i].e_ack));
      chk($sformatf("v%0d rf_we", i), 32'(bus.rf_we), 32'(tv[i].e_we));
      chk($sformatf("v%0d busy", i),  32'(bus.busy), 32'(tv[i].e_busy));
      chk($sformatf("v%0d ovf", i),   32'(bus.overflow), 32'(tv[i].e_ovf));
      chk($sformatf("v%0d hit", i),   32'(bus.fwd_hit), FWD_ON ? 32'(tv[i].e_hit) : 32'd0);
      if (tv[i].e_we) begin
        chk($sformatf("v%0d rf_addr", i), 32'(bus.rf_addr), 32'(tv[i].e_addr));
        chk($sformatf("v%0d rf_data", i), bus.rf_data, tv[i].e_data);
        chk($sformatf("v%0d fwd_data", i), bus.fwd_data, FWD_ON ? tv[i].e_data : 32'd0);
      end
    end

    // randomized traffic against a queue-level model
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 8'h00, 0, 0);
    q.delete();
    m_we = 0; m_ovf = 0; m_addr = '0; m_data = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_now = ($urandom_range(299) == 0);
      sh   = ($urandom_range(99) < 60);
      vl   = ($urandom_range(99) < 80);
      dest = 5'($urandom_range(31));
      src  = 3'($urandom_range(7));
      uv   = 8'($urandom) & 8'($urandom);
      data = $urandom;
      fa   = $urandom_range(1) ? m_addr : 5'($urandom_range(31));
      drive(rst_now, sh, vl, dest, src, uv, data, fa);
      if (rst_now) begin
        q.delete();
        m_we = 0;
        m_ovf = 0;
      end
      full  = (q.size() == DEPTH);
      pop   = !rst_now && q.size() != 0 && uv[q[0].src];
      e_ack = pop ? (8'd1 << q[0].src) : 8'd0;
      #1;
      chk("rnd stall", 32'(bus.stall), 32'(full));
      chk("rnd ack",   32'(bus.unit_ack), 32'(e_ack));
      chk("rnd rf_we", 32'(bus.rf_we), 32'(m_we));
      chk("rnd busy",  32'(bus.busy), 32'(q.size() != 0 || m_we));
      chk("rnd ovf",   32'(bus.overflow), 32'(m_ovf));
      chk("rnd hit",   32'(bus.fwd_hit), 32'(FWD_ON && m_we && fa == m_addr));
      if (m_we) begin
        chk("rnd rf_addr", 32'(bus.rf_addr), 32'(m_addr));
        chk("rnd rf_data", bus.rf_data, m_data);
        chk("rnd fwd_data", bus.fwd_data, FWD_ON ? m_data : 32'd0);
      end
      if (!rst_now) begin
        if (pop) begin
          m_addr = q[0].dest;
          m_data = data + 32'(q[0].src);
          q.delete(0);
        end
        m_we = pop;
        if (sh && vl) begin
          if (full) m_ovf = 1;
          else      q.push_back('{dest: dest, src: src});
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
